// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init + periodic auto-refresh sequencer; owns the command bus until init is done
// and reclaims it for PRECHARGE-all + AUTO REFRESH. Define SDRAM_SIM_FAST_EN for short sim timing.
module sdram_init_refresh #(
  parameter int          INIT_CYCLES  = 10000,
  parameter int          INIT_REFRESH = 8,
  parameter int          REF_INTERVAL = 390,
  parameter int          T_RP         = 1,
  parameter int          T_RFC        = 4,
  parameter int          T_MRD        = 2,
  parameter logic [12:0] MODE_REG     = 13'h0020
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ctl_idle,
  output logic        gnt,
  output logic        ready,
  output logic        ref_due,
  output logic        ref_overrun,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [12:0] addr,
  output logic [1:0]  ba,
  output logic [1:0]  dqm
);

`ifdef SDRAM_SIM_FAST_EN
  localparam int INIT_EFF = 16;
  localparam int REF_EFF  = 64;
`else
  localparam int INIT_EFF = INIT_CYCLES;
  localparam int REF_EFF  = REF_INTERVAL;
`endif

  // Wait states exit when the delay counter reaches 1, so each wait lasts exactly its load value
  // (T_* and INIT_CYCLES-1 must be >= 1). Waits that hand the bus back use T+1 so the controller's
  // first command still respects the full gap after the last sequencer command.
  localparam logic [15:0] INIT_LOAD     = 16'(INIT_EFF - 1);
  localparam logic [15:0] REF_LOAD      = 16'(REF_EFF - 1);
  localparam logic [15:0] RP_LOAD       = 16'(T_RP);
  localparam logic [15:0] RFC_LOAD      = 16'(T_RFC);
  localparam logic [15:0] RFC_IDLE_LOAD = 16'(T_RFC + 1);
  localparam logic [15:0] MRD_IDLE_LOAD = 16'(T_MRD + 1);
  localparam logic [7:0]  INIT_REF_N    = 8'(INIT_REFRESH);
  localparam logic [12:0] ADDR_ALL_BANK = 13'h0400;

  typedef enum logic [3:0] {
    S_RESET, S_INIT_WAIT, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_LMR, S_WAIT_MRD, S_IDLE
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_NOP = 4'b0111,
    CMD_INH = 4'b1111
  } cmd_t;

  state_t      state;
  cmd_t        cmd_q;
  logic [15:0] dly;
  logic [15:0] rtimer;
  logic [7:0]  ref_cnt;
  logic        dly_done;
  logic        ref_clr;
  logic        ref_hit;

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign dly_done = (dly <= 16'd1);
  assign ref_clr  = (state == S_REF) && ready;
  assign ref_hit  = ready && (rtimer == 16'd0);

  // NOTE: every register here is state, so it is written with <= only; mixing in blocking
  // assignments would make the result depend on statement order and simulator scheduling.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= S_RESET;
      cmd_q       <= CMD_INH;
      dly         <= 16'd0;
      rtimer      <= 16'd0;
      ref_cnt     <= 8'd0;
      cke         <= 1'b0;
      addr        <= 13'd0;
      ba          <= 2'd0;
      dqm         <= 2'b11;
      gnt         <= 1'b0;
      ready       <= 1'b0;
      ref_due     <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      cmd_q <= CMD_NOP;
      addr  <= 13'd0;
      ba    <= 2'd0;

      case (state)
        S_RESET: begin
          cke   <= 1'b1;
          dly   <= INIT_LOAD;
          state <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (dly_done) state <= S_PRE;
          else          dly   <= dly - 16'd1;
        end
        S_PRE: begin
          cmd_q <= CMD_PRE;
          addr  <= ADDR_ALL_BANK;
          dly   <= RP_LOAD;
          state <= S_WAIT_RP;
        end
        S_WAIT_RP: begin
          if (dly_done) state <= S_REF;
          else          dly   <= dly - 16'd1;
        end
        S_REF: begin
          cmd_q <= CMD_REF;
          state <= S_WAIT_RFC;
          if (ready) begin
            dly <= RFC_IDLE_LOAD;
          end else begin
            dly     <= RFC_LOAD;
            ref_cnt <= ref_cnt + 8'd1;
          end
        end
        S_WAIT_RFC: begin
          if (!dly_done) begin
            dly <= dly - 16'd1;
          end else if (ready) begin
            gnt   <= 1'b1;
            dqm   <= 2'b00;
            state <= S_IDLE;
          end else if (ref_cnt >= INIT_REF_N) begin
            state <= S_LMR;
          end else begin
            state <= S_REF;
          end
        end
        S_LMR: begin
          cmd_q <= CMD_LMR;
          addr  <= MODE_REG;
          dly   <= MRD_IDLE_LOAD;
          state <= S_WAIT_MRD;
        end
        S_WAIT_MRD: begin
          if (dly_done) begin
            gnt    <= 1'b1;
            dqm    <= 2'b00;
            ready  <= 1'b1;
            rtimer <= REF_LOAD;
            state  <= S_IDLE;
          end else begin
            dly <= dly - 16'd1;
          end
        end
        S_IDLE: begin
          if (ref_due && ctl_idle) begin
            gnt   <= 1'b0;
            dqm   <= 2'b11;
            state <= S_PRE;
          end
        end
        default: state <= S_RESET;
      endcase

      // Refresh timer runs from the end of init onward, including during a takeover. A deadline
      // landing on the REF cycle re-arms ref_due rather than counting as an overrun.
      if (ready) begin
        if (ref_hit) rtimer <= REF_LOAD;
        else         rtimer <= rtimer - 16'd1;
      end
      ref_due <= (ref_due && !ref_clr) || ref_hit;
      if (ref_hit && ref_due && !ref_clr) ref_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with INIT_CYCLES=16, REF_INTERVAL=64 and default timings;
// cycle 0 is the first cycle after n_reset is released (cke high).
module tb_sdram_init_refresh;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] INH = 4'b1111;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        ctl_idle;
  logic        gnt, ready, ref_due, ref_overrun, cke;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [12:0] addr;
  logic [1:0]  ba, dqm;

  sdram_init_refresh #(
    .INIT_CYCLES (16),
    .REF_INTERVAL(64)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .ctl_idle   (ctl_idle),
    .gnt        (gnt),
    .ready      (ready),
    .ref_due    (ref_due),
    .ref_overrun(ref_overrun),
    .cke        (cke),
    .cs_n       (cs_n),
    .ras_n      (ras_n),
    .cas_n      (cas_n),
    .we_n       (we_n),
    .addr       (addr),
    .ba         (ba),
    .dqm        (dqm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ctl;   // ctl_idle driven after this check; x keeps the current value
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        gnt;
    logic        ready;
    logic [1:0]  dqm;
    logic        due;
    logic        ovr;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   i_ref4, init_hi, ref_lo, i_pre127, ref_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic vec_t mk(input int c, input logic ctl, input logic [3:0] cmd,
                              input logic [12:0] a, input logic g, input logic r,
                              input logic [1:0] d, input logic due, input logic ovr);
    vec_t v;
    v.cyc = c; v.ctl = ctl; v.cmd = cmd; v.addr = a; v.gnt = g;
    v.ready = r; v.dqm = d; v.due = due; v.ovr = ovr;
    return v;
  endfunction

  function automatic void add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endfunction

  // Steps to v.cyc, requiring NOP on every cycle in between, then compares all outputs.
  task automatic expect_at(input vec_t v);
    while (cyc < v.cyc) begin
      step();
      if (cyc < v.cyc) check("between_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'(NOP));
    end
    check("cmd",         32'({cs_n, ras_n, cas_n, we_n}), 32'(v.cmd));
    check("addr",        32'(addr),        32'(v.addr));
    check("ba",          32'(ba),          32'd0);
    check("cke",         32'(cke),         32'd1);
    check("gnt",         32'(gnt),         32'(v.gnt));
    check("ready",       32'(ready),       32'(v.ready));
    check("dqm",         32'(dqm),         32'(v.dqm));
    check("ref_due",     32'(ref_due),     32'(v.due));
    check("ref_overrun", 32'(ref_overrun), 32'(v.ovr));
    if (v.ctl !== 1'bx) ctl_idle = v.ctl;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) expect_at(vecs[i]);
  endtask

  // One-cycle reset pulse; checks reset values on the edge it is sampled, then restarts cycle 0.
  task automatic do_reset();
    n_reset = 1'b0;
    step();
    check("rst_cke",   32'(cke),   32'd0);
    check("rst_cmd",   32'({cs_n, ras_n, cas_n, we_n}), 32'(INH));
    check("rst_addr",  32'(addr),  32'd0);
    check("rst_ba",    32'(ba),    32'd0);
    check("rst_dqm",   32'(dqm),   32'd3);
    check("rst_gnt",   32'(gnt),   32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_due",   32'(ref_due), 32'd0);
    check("rst_ovr",   32'(ref_overrun), 32'd0);
    n_reset = 1'b1;
    step();
    cyc = 0;
    check("cke_rise",  32'(cke),   32'd1);
  endtask

  initial begin
    n_reset  = 1'b0;
    ctl_idle = 1'b1;

    // Init: PRE at 16, eight REFs 5 apart from 18, LMR at 58, gnt/ready at 61.
    add(mk(0,  1'bx, NOP, 13'h0000, 0, 0, 2'b11, 0, 0));
    add(mk(15, 1'bx, NOP, 13'h0000, 0, 0, 2'b11, 0, 0));
    add(mk(16, 1'bx, PRE, 13'h0400, 0, 0, 2'b11, 0, 0));
    for (int k = 0; k < 8; k++) begin
      if (k == 3) i_ref4 = nvec;
      add(mk(18 + 5 * k, 1'bx, REF, 13'h0000, 0, 0, 2'b11, 0, 0));
    end
    add(mk(58, 1'bx, LMR, 13'h0020, 0, 0, 2'b11, 0, 0));
    add(mk(60, 1'bx, NOP, 13'h0000, 0, 0, 2'b11, 0, 0));
    add(mk(61, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    init_hi = nvec - 1;

    // Periodic refresh with ctl_idle held high: deadlines at 125 and 189, 8-cycle gnt gaps.
    ref_lo = nvec;
    add(mk(124, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    add(mk(125, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    add(mk(126, 1'b1, NOP, 13'h0000, 0, 1, 2'b11, 1, 0));
    i_pre127 = nvec;
    add(mk(127, 1'b1, PRE, 13'h0400, 0, 1, 2'b11, 1, 0));
    add(mk(129, 1'b1, REF, 13'h0000, 0, 1, 2'b11, 0, 0));
    add(mk(133, 1'b1, NOP, 13'h0000, 0, 1, 2'b11, 0, 0));
    add(mk(134, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    add(mk(188, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    add(mk(189, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    add(mk(190, 1'b1, NOP, 13'h0000, 0, 1, 2'b11, 1, 0));
    add(mk(191, 1'b1, PRE, 13'h0400, 0, 1, 2'b11, 1, 0));
    add(mk(193, 1'b1, REF, 13'h0000, 0, 1, 2'b11, 0, 0));
    add(mk(197, 1'b1, NOP, 13'h0000, 0, 1, 2'b11, 0, 0));
    add(mk(198, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    ref_hi = nvec - 1;

    repeat (3) @(posedge clk);
    #1;

    // Full init followed by two automatic refreshes.
    do_reset();
    run_range(0, init_hi);
    run_range(ref_lo, ref_hi);

    // Deadline pending while controller busy; released 10 cycles later.
    ctl_idle = 1'b0;
    do_reset();
    run_range(0, init_hi);
    expect_at(mk(124, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    expect_at(mk(125, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    expect_at(mk(135, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    expect_at(mk(136, 1'bx, NOP, 13'h0000, 0, 1, 2'b11, 1, 0));
    expect_at(mk(137, 1'bx, PRE, 13'h0400, 0, 1, 2'b11, 1, 0));
    expect_at(mk(139, 1'bx, REF, 13'h0000, 0, 1, 2'b11, 0, 0));
    expect_at(mk(143, 1'bx, NOP, 13'h0000, 0, 1, 2'b11, 0, 0));
    expect_at(mk(144, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    expect_at(mk(188, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 0));
    expect_at(mk(189, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));

    // Two full intervals without service: sticky overrun, one refresh only.
    ctl_idle = 1'b0;
    do_reset();
    run_range(0, init_hi);
    expect_at(mk(125, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    expect_at(mk(188, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 0));
    expect_at(mk(189, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 1));
    expect_at(mk(195, 1'b1, NOP, 13'h0000, 1, 1, 2'b00, 1, 1));
    expect_at(mk(196, 1'bx, NOP, 13'h0000, 0, 1, 2'b11, 1, 1));
    expect_at(mk(197, 1'bx, PRE, 13'h0400, 0, 1, 2'b11, 1, 1));
    expect_at(mk(199, 1'b0, REF, 13'h0000, 0, 1, 2'b11, 0, 1));
    expect_at(mk(204, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 1));
    expect_at(mk(252, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 0, 1));
    expect_at(mk(253, 1'bx, NOP, 13'h0000, 1, 1, 2'b00, 1, 1));

    // Reset during the 4th init REF, then a complete init again.
    ctl_idle = 1'b1;
    do_reset();
    run_range(0, i_ref4);
    do_reset();
    run_range(0, init_hi);

    // Reset mid-takeover (right after the PRE), then ready only after a complete init.
    run_range(ref_lo, i_pre127);
    do_reset();
    run_range(0, init_hi);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
